mm_arbiter: RTL and testbench

Two-port main-memory arbiter that lets two `cache` instances (e.g. instruction and data caches) share one main-memory block-read port. Each cache's `get`/`madr` request is granted round-robin. The block address is latched and forwarded to memory, and the returned 512-bit block is registered. The block is then handed back to the granted cache with a one-cycle `got` pulse, which matches what `cacheController` expects on its `got` input.

---
 rtl/mm_arbiter.sv | 139 +++++++++++++
 tb/tb_mm_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_arbiter.sv
// mm_arbiter: shares one main-memory block-read port between two cache requesters.
//
// Requests (get0/get1 with madr0/madr1) are granted round-robin. The granted
// address is latched onto mm_adr while mm_get is held. The block returned with
// mm_got is registered into mblk, and the owner gets a one-cycle got pulse.
//
// Ports:
//   clk, rst_b         clock (rising edge), asynchronous active-low reset
//   get0/madr0/got0    requester 0 request level, block address, done pulse
//   get1/madr1/got1    requester 1 request level, block address, done pulse
//   mblk               registered block, valid in the got cycle
//   mm_get/mm_adr      read request level and latched address to memory
//   mm_got/mm_blk      memory data strobe and data
//   owner              index of the granted requester (held while idle)
//   busy               transaction in progress (issue or deliver)
//   clr_cnt/wait_cnt   synchronous clear and saturating contention counter
module mm_arbiter #(
  parameter int unsigned AW = 27,
  parameter int unsigned BW = 512,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          get0,
  input  logic [AW-1:0] madr0,
  output logic          got0,
  input  logic          get1,
  input  logic [AW-1:0] madr1,
  output logic          got1,
  output logic [BW-1:0] mblk,
  output logic          mm_get,
  output logic [AW-1:0] mm_adr,
  input  logic          mm_got,
  input  logic [BW-1:0] mm_blk,
  output logic          owner,
  output logic          busy,
  input  logic          clr_cnt,
  output logic [CW-1:0] wait_cnt
);

  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StIssue   = 3'b010,
    StDeliver = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_vld;
  logic grant_idx;
  logic busy_w;
  logic wait0;
  logic wait1;

  // With both requesting, the round-robin pointer decides; otherwise the lone requester wins.
  assign grant_vld = get0 | get1;
  assign grant_idx = (get0 & get1) ? rr_q : get1;

  assign busy_w = (state_q == StIssue) || (state_q == StDeliver);

  // A requester is waiting whenever it asks but is not the one currently being served.
  assign wait0 = get0 & ~(busy_w & (owner_q == 1'b0));
  assign wait1 = get1 & ~(busy_w & (owner_q == 1'b1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    adr_d   = adr_q;
    blk_d   = blk_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = StIssue;
          owner_d = grant_idx;
          adr_d   = grant_idx ? madr1 : madr0;
          rr_d    = ~grant_idx;
        end
      end
      StIssue: begin
        if (mm_got) begin
          blk_d   = mm_blk;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if ((wait0 | wait1) && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      adr_q   <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      adr_q   <= adr_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs are registers or decodes of the registered state.
  assign mm_get   = (state_q == StIssue);
  assign mm_adr   = adr_q;
  assign got0     = (state_q == StDeliver) && (owner_q == 1'b0);
  assign got1     = (state_q == StDeliver) && (owner_q == 1'b1);
  assign mblk     = blk_q;
  assign owner    = owner_q;
  assign busy     = busy_w;
  assign wait_cnt = cnt_q;

endmodule

// File: tb/tb_mm_arbiter.sv
// Scoreboard bench for mm_arbiter: each test pushes the expected deliveries
// (requester, address, block) in grant order; the monitor pops one per got pulse.
module tb_mm_arbiter;

  localparam int unsigned AW = 27;
  localparam int unsigned BW = 512;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          get0, get1;
  logic [AW-1:0] madr0, madr1;
  logic          got0, got1;
  logic [BW-1:0] mblk;
  logic          mm_get;
  logic [AW-1:0] mm_adr;
  logic          mm_got;
  logic [BW-1:0] mm_blk;
  logic          owner;
  logic          busy;
  logic          clr_cnt;
  logic [CW-1:0] wait_cnt;

  always #5 clk = ~clk;

  mm_arbiter #(.AW(AW), .BW(BW), .CW(CW)) u_dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .get0     (get0),
    .madr0    (madr0),
    .got0     (got0),
    .get1     (get1),
    .madr1    (madr1),
    .got1     (got1),
    .mblk     (mblk),
    .mm_get   (mm_get),
    .mm_adr   (mm_adr),
    .mm_got   (mm_got),
    .mm_blk   (mm_blk),
    .owner    (owner),
    .busy     (busy),
    .clr_cnt  (clr_cnt),
    .wait_cnt (wait_cnt)
  );

  typedef struct {
    logic          id;
    logic [AW-1:0] adr;
    logic [BW-1:0] blk;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] adr_q0[$];
  logic [AW-1:0] adr_q1[$];

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_got_cyc = 0;
  int            mem_lat = 3;
  int            lat_cnt = 0;
  int            c0;
  bit            mem_en = 1'b1;
  bit            spur = 1'b0;
  bit            fixed_en = 1'b0;
  logic [BW-1:0] fixed_blk = '0;
  logic [BW-1:0] last_blk = '0;

  function automatic logic [BW-1:0] blk_of(input logic [AW-1:0] a);
    return (BW'(a) << 400) | BW'({a, 5'h15});
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [AW-1:0] a);
    exp_t e;
    e.id  = id;
    e.adr = a;
    e.blk = blk_of(a);
    sb.push_back(e);
  endtask

  // Checks each got pulse against the scoreboard and plays the requester side.
  task automatic monitor();
    exp_t e;
    if (got0 || got1) begin
      chk("got_excl", got0 & got1, 0);
      chk("got_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("got_id", got1, e.id);
        chk("owner", owner, e.id);
        chk("mm_adr", mm_adr, e.adr);
        chk("mblk", mblk, e.blk);
        last_blk = e.blk;
      end
      last_got_cyc = cyc;
      if (got0) begin
        if (adr_q0.size() > 0) begin
          madr0 = adr_q0.pop_front();
          get0  = 1'b1;
        end else begin
          get0 = 1'b0;
        end
      end
      if (got1) begin
        if (adr_q1.size() > 0) begin
          madr1 = adr_q1.pop_front();
          get1  = 1'b1;
        end else begin
          get1 = 1'b0;
        end
      end
    end
  endtask

  // Memory answers mem_lat cycles after mm_get rises, with a one-cycle mm_got.
  task automatic memory();
    if (mm_got) begin
      mm_got = 1'b0;
    end else if (spur) begin
      mm_got = 1'b1;
      mm_blk = {16{32'hDEADBEEF}};
      spur   = 1'b0;
    end else if (mm_get && mem_en) begin
      if (lat_cnt >= mem_lat - 1) begin
        mm_got  = 1'b1;
        mm_blk  = fixed_en ? fixed_blk : blk_of(mm_adr);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
    memory();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && !(sb.size() == 0 && !busy); i++) tick();
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    rst_b   = 1'b1;
    get0    = 1'b0;
    get1    = 1'b0;
    madr0   = '0;
    madr1   = '0;
    mm_got  = 1'b0;
    mm_blk  = '0;
    clr_cnt = 1'b0;

    // Reset values
    #1 rst_b = 1'b0;
    #1;
    chk("rst_mm_get", mm_get, 0);
    chk("rst_mm_adr", mm_adr, 0);
    chk("rst_mblk", mblk, 0);
    chk("rst_got0", got0, 0);
    chk("rst_got1", got1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_cnt", wait_cnt, 0);
    tick();
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_mm_get", mm_get, 0);
    end
    chk("idle_cnt", wait_cnt, 0);

    // Single request, memory answers 3 cycles after mm_get rises
    mem_lat   = 3;
    fixed_en  = 1'b1;
    fixed_blk = 512'd1234;
    begin
      exp_t e;
      e.id  = 1'b0;
      e.adr = 27'h123;
      e.blk = 512'd1234;
      sb.push_back(e);
    end
    madr0 = 27'h123;
    get0  = 1'b1;
    c0    = cyc;
    tick();
    chk("issue_mm_get", mm_get, 1);
    chk("issue_adr", mm_adr, 27'h123);
    wait_drain(20);
    chk("lat_single", last_got_cyc - c0, 4);
    fixed_en = 1'b0;

    // Minimum latency: memory answers in the first issue cycle
    mem_lat = 1;
    push_exp(1'b1, 27'h0ABCDE);
    madr1 = 27'h0ABCDE;
    get1  = 1'b1;
    c0    = cyc;
    wait_drain(20);
    chk("lat_min", last_got_cyc - c0, 2);

    // Simultaneous requests: 0 first, then 1; requester 1 waits through
    // idle(1) + issue(mem_lat) + deliver(1) + idle(1) cycles
    mem_lat = 3;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_idle", wait_cnt, 0);
    push_exp(1'b0, 27'h1000001);
    push_exp(1'b1, 27'h2000002);
    madr0 = 27'h1000001;
    madr1 = 27'h2000002;
    get0  = 1'b1;
    get1  = 1'b1;
    wait_drain(40);
    chk("wait_sim", wait_cnt, mem_lat + 3);

    // Fairness: continuous re-requests alternate 0,1,0,1,0,1
    mem_lat = 2;
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 27'h0300000 + 27'(k));
      push_exp(1'b1, 27'h0400000 + 27'(k));
      if (k > 0) begin
        adr_q0.push_back(27'h0300000 + 27'(k));
        adr_q1.push_back(27'h0400000 + 27'(k));
      end
    end
    madr0 = 27'h0300000;
    madr1 = 27'h0400000;
    get0  = 1'b1;
    get1  = 1'b1;
    wait_drain(100);

    // Spurious mm_got while idle is ignored
    tick();
    spur = 1'b1;
    tick();
    tick();
    chk("spur_busy", busy, 0);
    chk("spur_mm_get", mm_get, 0);
    chk("spur_mblk", mblk, last_blk);
    tick();
    tick();

    // Reset during issue aborts at once, without a got pulse
    mem_lat = 5;
    madr1   = 27'h0555555;
    get1    = 1'b1;
    tick();
    tick();
    chk("abort_pre", mm_get, 1);
    chk("abort_pre_owner", owner, 1);
    #3;
    rst_b = 1'b0;
    get1  = 1'b0;
    #1;
    chk("abort_mm_get", mm_get, 0);
    chk("abort_busy", busy, 0);
    chk("abort_owner", owner, 0);
    chk("abort_adr", mm_adr, 0);
    chk("abort_mblk", mblk, 0);
    tick();
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_req", mm_get, 0);
    end

    // Persistent waiter saturates the 4-bit counter; clear beats increment
    mem_en = 1'b0;
    push_exp(1'b0, 27'h0600000);
    push_exp(1'b1, 27'h0700000);
    madr0 = 27'h0600000;
    madr1 = 27'h0700000;
    get0  = 1'b1;
    get1  = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_adr", mm_adr, 27'h0600000);
    chk("sat_cnt", wait_cnt, 4'hF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_prio", wait_cnt, 0);
    tick();
    chk("cnt_resume", wait_cnt, 1);
    mem_lat = 2;
    mem_en  = 1'b1;
    wait_drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
